// File: rtl/rr_mux2_arbiter.sv
// Round-robin arbiter for two valid/ready packet streams feeding a 2:1 mux.
// Grants are locked for the length of a packet. The chosen beat lands in a one-deep output register.
module rr_mux2_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             in1_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_src,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOCK0 = 2'd1;
  localparam logic [1:0] LOCK1 = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             out_src_q, out_src_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic load;
  logic grant;
  logic accept;

  assign load = !out_valid_q || out_ready;

  always_comb begin
    grant = last_grant_q;
    case (state_q)
      LOCK0:   grant = 1'b0;
      LOCK1:   grant = 1'b1;
      default: begin
        if (in0_valid && !in1_valid)      grant = 1'b0;
        else if (in1_valid && !in0_valid) grant = 1'b1;
        else if (in0_valid && in1_valid)  grant = !last_grant_q;
        else                              grant = last_grant_q;
      end
    endcase
    // While the output is stalled, sel is pinned to the last decision.
    // In a locked state that value equals the forced grant.
    if (!load) grant = last_grant_q;
  end

  assign in0_ready = load && !grant && in0_valid;
  assign in1_ready = load &&  grant && in1_valid;
  assign accept    = in0_ready || in1_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_src_d    = out_src_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    if (load) out_valid_d = accept;
    if (accept) begin
      out_data_d   = grant ? in1_data : in0_data;
      out_last_d   = grant ? in1_last : in0_last;
      out_src_d    = grant;
      last_grant_d = grant;
      if (grant) cnt1_d = cnt1_q + CNT_W'(1);
      else       cnt0_d = cnt0_q + CNT_W'(1);
      if (out_last_d) state_d = IDLE;
      else            state_d = grant ? LOCK1 : LOCK0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_src_q    <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_src_q    <= out_src_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign sel       = grant;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;

endmodule
